// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 cracker result streamer.
// Holds the FSM state enum, the ASCII framing bytes and the key-nibble selector.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KEY_EMIT,
    ST_SEP_EMIT,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_MSG_EMIT,
    ST_TERM_EMIT,
    ST_FAIL_EMIT,
    ST_DONE
  } state_e;

  localparam int MSG_LEN_DEFAULT = 32;
  localparam int RD_LAT_DEFAULT  = 2;
  localparam int KEY_NIBBLES     = 6;

  localparam logic [7:0] ASCII_SEP  = 8'h3A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_BANG = 8'h21;

  // sel 0 is the most significant nibble, so the key prints left to right
  function automatic logic [3:0] key_nibble(input logic [23:0] key, input logic [2:0] sel);
    logic [3:0] nib;
    case (sel)
      3'd0:    nib = key[23:20];
      3'd1:    nib = key[19:16];
      3'd2:    nib = key[15:12];
      3'd3:    nib = key[11:8];
      3'd4:    nib = key[7:4];
      default: nib = key[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to lower-case ASCII hex digit.
module hex_to_ascii (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) ascii_o = 8'h30 + {4'h0, nibble_i};
    else                  ascii_o = 8'h57 + {4'h0, nibble_i};
  end

endmodule

// File: rtl/rc4_result_streamer.sv
// Streams the cracked key and decrypted message as ASCII over a valid/ready link.
// state        | meaning
// ST_IDLE      | waiting for success or fail level from the cracker
// ST_KEY_EMIT  | offering the six hex digits of the latched key
// ST_SEP_EMIT  | offering ':'
// ST_RD_ADDR   | message address presented to the RAM
// ST_RD_WAIT   | waiting out the RAM read latency
// ST_MSG_EMIT  | offering one message byte
// ST_TERM_EMIT | offering CR after the message
// ST_FAIL_EMIT | offering '!' then CR
// ST_DONE      | stream finished, held until reset
module rc4_result_streamer
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int RD_LAT  = RD_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        success_led,
  input  logic        fail_led,
  input  logic [23:0] secret_key,
  output logic [7:0]  d_addr,
  input  logic [7:0]  d_rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] key_latched,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);
  localparam int         WAIT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT - 1);
  localparam logic [2:0] LAST_NIB = 3'(KEY_NIBBLES - 1);

  state_e            state_q;
  logic [2:0]        nib_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [7:0]        idx_q;
  logic [7:0]        out_data_q;
  logic              out_valid_q;
  logic [7:0]        d_addr_q;
  logic [23:0]       key_q;
  logic              busy_q;
  logic              done_q;

  logic [23:0] key_src_d;
  logic [2:0]  nib_sel_d;
  logic [3:0]  nib_val_d;
  logic [7:0]  nib_ascii;
  logic        xfer;

  assign xfer = out_valid_q & out_ready;

  // In IDLE the first digit comes straight from secret_key, since key_q loads on the same edge
  always_comb begin
    key_src_d = key_q;
    nib_sel_d = nib_cnt_q + 3'd1;
    if (state_q == ST_IDLE) begin
      key_src_d = secret_key;
      nib_sel_d = 3'd0;
    end
    nib_val_d = key_nibble(key_src_d, nib_sel_d);
  end

  hex_to_ascii u_hex_to_ascii (
    .nibble_i (nib_val_d),
    .ascii_o  (nib_ascii)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      nib_cnt_q   <= 3'd0;
      wait_cnt_q  <= '0;
      idx_q       <= 8'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      d_addr_q    <= 8'd0;
      key_q       <= 24'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (success_led) begin
            key_q       <= secret_key;
            busy_q      <= 1'b1;
            nib_cnt_q   <= 3'd0;
            out_data_q  <= nib_ascii;
            out_valid_q <= 1'b1;
            state_q     <= ST_KEY_EMIT;
          end else if (fail_led) begin
            busy_q      <= 1'b1;
            nib_cnt_q   <= 3'd0;
            out_data_q  <= ASCII_BANG;
            out_valid_q <= 1'b1;
            state_q     <= ST_FAIL_EMIT;
          end
        end

        ST_KEY_EMIT: begin
          if (xfer) begin
            if (nib_cnt_q == LAST_NIB) begin
              out_data_q <= ASCII_SEP;
              state_q    <= ST_SEP_EMIT;
            end else begin
              nib_cnt_q  <= nib_cnt_q + 3'd1;
              out_data_q <= nib_ascii;
            end
          end
        end

        ST_SEP_EMIT: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            idx_q       <= 8'd0;
            d_addr_q    <= 8'd0;
            state_q     <= ST_RD_ADDR;
          end
        end

        ST_RD_ADDR: begin
          wait_cnt_q <= WAIT_LOAD;
          state_q    <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (wait_cnt_q == '0) begin
            out_data_q  <= d_rdata;
            out_valid_q <= 1'b1;
            state_q     <= ST_MSG_EMIT;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end

        ST_MSG_EMIT: begin
          if (xfer) begin
            if (idx_q < LAST_IDX) begin
              idx_q       <= idx_q + 8'd1;
              d_addr_q    <= idx_q + 8'd1;
              out_valid_q <= 1'b0;
              state_q     <= ST_RD_ADDR;
            end else begin
              out_data_q <= ASCII_CR;
              state_q    <= ST_TERM_EMIT;
            end
          end
        end

        ST_TERM_EMIT: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end
        end

        // nib_cnt_q doubles as the byte counter for the two-byte failure message
        ST_FAIL_EMIT: begin
          if (xfer) begin
            if (nib_cnt_q == 3'd0) begin
              nib_cnt_q  <= 3'd1;
              out_data_q <= ASCII_CR;
            end else begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
        end

        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign d_addr      = d_addr_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign key_latched = key_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
